// File: rtl/axi_wr_issue_gate.sv
// axi_wr_issue_gate: caps outstanding AXI4 write transactions, keeps W beats
// behind their AW, regenerates WLAST from the accepted AWLEN and flags
// WLAST / B-response protocol violations with one-cycle pulses.
module axi_wr_issue_gate #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    // AW channel
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [14:0]           s_axi_awattr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [14:0]           m_axi_awattr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // W channel
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // B channel
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    // status
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  wlast_err,
    output logic                  b_err
);

    // Length FIFO geometry: index bits plus one wrap bit for full/empty.
    localparam int unsigned IDX_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned PTR_W      = IDX_W + 1;
    localparam int unsigned FIFO_DEPTH = 1 << IDX_W;

    logic [CNT_WIDTH-1:0] outstanding_reg;
    logic [7:0]           beat_cnt_reg;
    logic [7:0]           len_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 wlast_err_reg;
    logic                 b_err_reg;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 limit;
    logic                 head_valid;
    logic [7:0]           head_len;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 b_hs;

    // FIFO status and the issue gates derived from it.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        limit      = (outstanding_reg == CNT_WIDTH'(MAX_OUTSTANDING)) || fifo_full || rst;
        // Reset also blocks W so an abandoned burst cannot leak a beat.
        head_valid = !fifo_empty && !rst;
        head_len   = len_mem[rd_ptr[IDX_W-1:0]];
    end

    // AW pass-through, gated by the outstanding/FIFO limit.
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awattr  = s_axi_awattr;
    assign m_axi_awvalid = s_axi_awvalid & !limit;
    assign s_axi_awready = m_axi_awready & !limit;

    // W pass-through, held until the burst's length is at the FIFO head.
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wvalid  = s_axi_wvalid & head_valid;
    assign s_axi_wready  = m_axi_wready & head_valid;
    assign m_axi_wlast   = head_valid && (beat_cnt_reg == head_len);

    // B pass-through, live even during reset.
    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;

    assign outstanding = outstanding_reg;
    assign wlast_err   = wlast_err_reg;
    assign b_err       = b_err_reg;

    // Length FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            len_mem[wr_ptr[IDX_W-1:0]] <= s_axi_awlen;
        end
    end

    // FIFO pointers and per-burst beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            beat_cnt_reg <= '0;
        end else begin
            if (aw_hs) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (w_hs) begin
                if (m_axi_wlast) begin
                    rd_ptr       <= rd_ptr + PTR_W'(1);
                    beat_cnt_reg <= '0;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 8'(1);
                end
            end
        end
    end

    // Outstanding count: +1 per AW, -1 per B, saturating at zero on stray B.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_WIDTH'(1);
                2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - CNT_WIDTH'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Registered one-cycle protocol error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wlast_err_reg <= 1'b0;
            b_err_reg     <= 1'b0;
        end else begin
            wlast_err_reg <= w_hs && (s_axi_wlast != m_axi_wlast);
            b_err_reg     <= b_hs && (outstanding_reg == '0);
        end
    end

endmodule

// File: tb/tb_axi_wr_issue_gate.sv
// Directed bench for axi_wr_issue_gate: inputs change 1 time unit after the
// rising edge, outputs are sampled 1 unit later, well away from the edge.
module tb_axi_wr_issue_gate;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 8;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO + 1);

    logic          clk;
    logic          rst;
    logic [IW-1:0] s_axi_awid,    m_axi_awid;
    logic [AW-1:0] s_axi_awaddr,  m_axi_awaddr;
    logic [7:0]    s_axi_awlen,   m_axi_awlen;
    logic [2:0]    s_axi_awsize,  m_axi_awsize;
    logic [1:0]    s_axi_awburst, m_axi_awburst;
    logic [14:0]   s_axi_awattr,  m_axi_awattr;
    logic          s_axi_awvalid, m_axi_awvalid;
    logic          s_axi_awready, m_axi_awready;
    logic [DW-1:0] s_axi_wdata,   m_axi_wdata;
    logic [SW-1:0] s_axi_wstrb,   m_axi_wstrb;
    logic          s_axi_wlast,   m_axi_wlast;
    logic          s_axi_wvalid,  m_axi_wvalid;
    logic          s_axi_wready,  m_axi_wready;
    logic [IW-1:0] m_axi_bid,     s_axi_bid;
    logic [1:0]    m_axi_bresp,   s_axi_bresp;
    logic          m_axi_bvalid,  s_axi_bvalid;
    logic          s_axi_bready,  m_axi_bready;
    logic [CW-1:0] outstanding;
    logic          wlast_err;
    logic          b_err;

    int total = 0;
    int bad   = 0;

    axi_wr_issue_gate #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awattr(s_axi_awattr),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awattr(m_axi_awattr),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .outstanding(outstanding), .wlast_err(wlast_err), .b_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        s_axi_awid = 8'h00; s_axi_awaddr = '0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awattr = 15'h0; s_axi_awvalid = 1'b0;
        m_axi_awready = 1'b1;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_wready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;

        // ---- reset behaviour ----
        cyc(); cyc();
        s_axi_awvalid = 1'b1; m_axi_bvalid = 1'b1; m_axi_bid = 8'h33;
        #1;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_bvalid_pass", 64'(s_axi_bvalid), 64'd1);
        chk("rst_bid_pass", 64'(s_axi_bid), 64'h33);
        cyc();
        rst = 1'b0; s_axi_awvalid = 1'b0; m_axi_bvalid = 1'b0; s_axi_wvalid = 1'b1;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        chk("rst_b_err", 64'(b_err), 64'd0);
        chk("rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_s_wready", 64'(s_axi_wready), 64'd0);

        // ---- single burst awlen=3, W valid alongside AW ----
        cyc();
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd3; s_axi_awid = 8'h5a;
        s_axi_awaddr = 32'h0000_1000; s_axi_awattr = 15'h1234;
        s_axi_wdata = 32'hcafe_0000; s_axi_wstrb = 4'hf;
        #1;
        chk("sb_m_awvalid", 64'(m_axi_awvalid), 64'd1);
        chk("sb_s_awready", 64'(s_axi_awready), 64'd1);
        chk("sb_awid", 64'(m_axi_awid), 64'h5a);
        chk("sb_awaddr", 64'(m_axi_awaddr), 64'h1000);
        chk("sb_awlen", 64'(m_axi_awlen), 64'd3);
        chk("sb_awattr", 64'(m_axi_awattr), 64'h1234);
        chk("sb_w_held", 64'(s_axi_wready), 64'd0);
        cyc();
        s_axi_awvalid = 1'b0;
        #1;
        chk("sb_outstanding1", 64'(outstanding), 64'd1);
        for (int i = 0; i < 4; i++) begin
            s_axi_wdata = 32'h100 + 32'(i);
            s_axi_wlast = (i == 3);
            #1;
            chk("sb_m_wvalid", 64'(m_axi_wvalid), 64'd1);
            chk("sb_wdata", 64'(m_axi_wdata), 64'h100 + 64'(i));
            chk("sb_wlast", 64'(m_axi_wlast), (i == 3) ? 64'd1 : 64'd0);
            cyc();
            #1;
            chk("sb_no_wlast_err", 64'(wlast_err), 64'd0);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        #1;
        chk("sb_fifo_drained", 64'(s_axi_wready), 64'd0);
        m_axi_bvalid = 1'b1; m_axi_bid = 8'h5a; m_axi_bresp = 2'b10; s_axi_bready = 1'b1;
        #1;
        chk("sb_bvalid", 64'(s_axi_bvalid), 64'd1);
        chk("sb_bresp", 64'(s_axi_bresp), 64'd2);
        chk("sb_bready", 64'(m_axi_bready), 64'd1);
        cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("sb_outstanding0", 64'(outstanding), 64'd0);
        chk("sb_no_b_err", 64'(b_err), 64'd0);

        // ---- outstanding limit: 4 accepted, 5th held ----
        s_axi_bready = 1'b0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lim_accept", 64'(s_axi_awready), 64'd1);
            cyc();
        end
        #1;
        chk("lim_outstanding4", 64'(outstanding), 64'd4);
        chk("lim_held_ready", 64'(s_axi_awready), 64'd0);
        chk("lim_held_valid", 64'(m_axi_awvalid), 64'd0);
        cyc();
        s_axi_wvalid = 1'b0;
        #1;
        chk("lim_still4", 64'(outstanding), 64'd4);
        chk("lim_still_held", 64'(s_axi_awready), 64'd0);
        chk("lim_fifo_empty", 64'(s_axi_wready), 64'd0);
        m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
        #1;
        chk("lim_no_comb_release", 64'(s_axi_awready), 64'd0);
        cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("lim_outstanding3", 64'(outstanding), 64'd3);
        chk("lim_released", 64'(s_axi_awready), 64'd1);
        cyc();
        s_axi_awvalid = 1'b0;
        #1;
        chk("lim_fifth_in", 64'(outstanding), 64'd4);
        s_axi_wvalid = 1'b1;
        cyc();
        s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("lim_drained", 64'(outstanding), 64'd0);
        chk("lim_no_b_err", 64'(b_err), 64'd0);
        chk("lim_no_wlast_err", 64'(wlast_err), 64'd0);

        // ---- W valid 3 cycles before AW ----
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wdata = 32'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("early_w_wready", 64'(s_axi_wready), 64'd0);
            chk("early_w_wvalid", 64'(m_axi_wvalid), 64'd0);
            cyc();
        end
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd0;
        #1;
        chk("early_w_same_cycle", 64'(s_axi_wready), 64'd0);
        cyc();
        s_axi_awvalid = 1'b0;
        #1;
        chk("early_w_released", 64'(s_axi_wready), 64'd1);
        chk("early_w_wlast", 64'(m_axi_wlast), 64'd1);
        chk("early_w_data", 64'(m_axi_wdata), 64'hdead_beef);
        cyc();
        s_axi_wvalid = 1'b0;
        #1;
        chk("early_w_no_err", 64'(wlast_err), 64'd0);

        // ---- WLAST mismatch, awlen=1 ----
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd1;
        cyc();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        #1;
        chk("mm_beat1_valid", 64'(m_axi_wvalid), 64'd1);
        chk("mm_beat1_wlast", 64'(m_axi_wlast), 64'd0);
        cyc();
        #1;
        chk("mm_err_pulse", 64'(wlast_err), 64'd1);
        chk("mm_beat2_wlast", 64'(m_axi_wlast), 64'd1);
        cyc();
        s_axi_wvalid = 1'b0;
        #1;
        chk("mm_err_once", 64'(wlast_err), 64'd0);
        chk("mm_outstanding2", 64'(outstanding), 64'd2);

        // ---- simultaneous AW and B, then stray B ----
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd0; m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
        cyc();
        s_axi_awvalid = 1'b0; m_axi_bvalid = 1'b0;
        #1;
        chk("sim_unchanged", 64'(outstanding), 64'd2);
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; m_axi_bvalid = 1'b1;
        cyc();
        s_axi_wvalid = 1'b0;
        cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("sim_drained", 64'(outstanding), 64'd0);
        chk("sim_no_b_err", 64'(b_err), 64'd0);
        m_axi_bvalid = 1'b1;
        cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("stray_b_err", 64'(b_err), 64'd1);
        chk("stray_b_hold0", 64'(outstanding), 64'd0);
        cyc();
        #1;
        chk("stray_b_err_once", 64'(b_err), 64'd0);

        // ---- reset during beat 2 of an awlen=7 burst ----
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd7;
        cyc();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0;
        #1;
        chk("rmb_beat1_wlast", 64'(m_axi_wlast), 64'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("rmb_wvalid_in_rst", 64'(m_axi_wvalid), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rmb_outstanding", 64'(outstanding), 64'd0);
        chk("rmb_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rmb_wready", 64'(s_axi_wready), 64'd0);
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd0; s_axi_wlast = 1'b1;
        #1;
        chk("rmb_new_aw_ready", 64'(s_axi_awready), 64'd1);
        cyc();
        s_axi_awvalid = 1'b0;
        #1;
        chk("rmb_new_outstanding", 64'(outstanding), 64'd1);
        chk("rmb_new_wvalid", 64'(m_axi_wvalid), 64'd1);
        chk("rmb_new_wlast", 64'(m_axi_wlast), 64'd1);
        cyc();
        s_axi_wvalid = 1'b0;
        #1;
        chk("rmb_no_err", 64'(wlast_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
